// File: rtl/prism_aux_engine.sv
// Auxiliary resources for the PRISM controller: countdown counters, an event counter with compare,
// a serial shift register and a sticky W1C status register with IRQ masking, all on the TinyQV bus.
module prism_aux_engine #(
    parameter int SHIFT_W = 8,
    parameter int CNT_W   = 24,
    parameter int NUM_CNT = 2,
    parameter int EVT_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         addr,
    input  logic [31:0]        wdata,
    input  logic               wr,
    output logic [31:0]        rdata,
    input  logic               enable,
    input  logic               halt,
    input  logic [NUM_CNT-1:0] ctl_load,
    input  logic [NUM_CNT-1:0] ctl_dec,
    input  logic               ctl_shift,
    input  logic               ctl_evt_clr,
    input  logic               ctl_evt_inc,
    input  logic [3:0]         ser_in,
    output logic               shift_bit,
    output logic [NUM_CNT-1:0] cnt_zero,
    output logic               cnt0_msb,
    output logic               evt_match,
    output logic               irq
);

    logic               go;
    logic               dir;
    logic [1:0]         sin_sel;
    logic               chain0;
    logic [3:0]         cnt_irq_en;
    logic               evt_irq_en;
    logic [SHIFT_W-1:0] sr;
    logic [SHIFT_W-1:0] sr_shifted;
    logic               sin_bit;
    logic [EVT_W-1:0]   evt_cmp;
    logic [EVT_W-1:0]   evt_cnt;
    logic               evt_match_q;
    logic [4:0]         status;
    logic [4:0]         status_set;
    logic [4:0]         status_clr;
    logic [CNT_W-1:0]   preload [NUM_CNT];
    logic [CNT_W-1:0]   cnt     [NUM_CNT];
    logic               unused_wdata;

    assign go           = enable && !halt;
    assign sin_bit      = ser_in[sin_sel];
    assign evt_match    = (evt_cnt == evt_cmp);
    assign shift_bit    = dir ? sr[0] : sr[SHIFT_W-1];
    assign cnt0_msb     = cnt[0][CNT_W-1];
    assign irq          = |(status & {evt_irq_en, cnt_irq_en});
    assign status_clr   = (wr && addr == 6'h0C) ? wdata[4:0] : 5'b0;
    assign unused_wdata = ^wdata;

    generate
        if (SHIFT_W == 1) begin : g_sr1
            assign sr_shifted = sin_bit;
        end else begin : g_srn
            assign sr_shifted = dir ? {sin_bit, sr[SHIFT_W-1:1]} : {sr[SHIFT_W-2:0], sin_bit};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            dir        <= 1'b0;
            sin_sel    <= 2'b0;
            chain0     <= 1'b0;
            cnt_irq_en <= 4'b0;
            evt_irq_en <= 1'b0;
        end else if (wr && addr == 6'h00) begin
            dir        <= wdata[0];
            sin_sel    <= wdata[2:1];
            chain0     <= wdata[3];
            cnt_irq_en <= wdata[19:16];
            evt_irq_en <= wdata[20];
        end
    end

    // A bus write to SHIFT wins over a PRISM shift request in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr <= '0;
        end else if (wr && addr == 6'h04) begin
            sr <= wdata[SHIFT_W-1:0];
        end else if (go && ctl_shift) begin
            sr <= sr_shifted;
        end
    end

    // Counter 0 doubles as a left-shifter when chained to the shift strobe and otherwise idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CNT; i++) begin
                preload[i] <= '0;
                cnt[i]     <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CNT; i++) begin
                if (wr && addr == 6'(16 + 4 * i)) begin
                    preload[i] <= wdata[CNT_W-1:0];
                end
                if (go && ctl_load[i] && !ctl_dec[i]) begin
                    cnt[i] <= preload[i];
                end else if (go && ctl_dec[i] && !ctl_load[i]) begin
                    if (cnt[i] != '0) begin
                        cnt[i] <= cnt[i] - CNT_W'(1);
                    end
                end else if (i == 0 && go && chain0 && ctl_shift && !ctl_load[i] && !ctl_dec[i]) begin
                    cnt[i] <= cnt[i] << 1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            evt_cmp     <= '0;
            evt_cnt     <= '0;
            evt_match_q <= 1'b1;
        end else begin
            if (wr && addr == 6'h08) begin
                evt_cmp <= wdata[EVT_W-1:0];
            end
            if (go && ctl_evt_clr && !ctl_evt_inc) begin
                evt_cnt <= '0;
            end else if (go && ctl_evt_inc && !ctl_evt_clr) begin
                evt_cnt <= evt_cnt + EVT_W'(1);
            end
            evt_match_q <= evt_match;
        end
    end

    // Only a real 1->0 decrement counts as a zero hit; loading zero does not.
    always_comb begin
        status_set = '0;
        for (int i = 0; i < NUM_CNT; i++) begin
            status_set[i] = go && ctl_dec[i] && !ctl_load[i] && (cnt[i] == CNT_W'(1));
        end
        status_set[4] = evt_match && !evt_match_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            status <= '0;
        end else begin
            status <= (status & ~status_clr) | status_set;
        end
    end

    always_comb begin
        cnt_zero = '0;
        for (int i = 0; i < NUM_CNT; i++) begin
            cnt_zero[i] = (cnt[i] == '0);
        end
    end

    always_comb begin
        rdata = '0;
        case (addr)
            6'h00: rdata = {11'b0, evt_irq_en, cnt_irq_en, 12'b0, chain0, sin_sel, dir};
            6'h04: rdata[SHIFT_W-1:0] = sr;
            6'h08: begin
                rdata[EVT_W-1:0]  = evt_cmp;
                rdata[16 +: EVT_W] = evt_cnt;
            end
            6'h0C: rdata[4:0] = status;
            default: begin
                for (int i = 0; i < NUM_CNT; i++) begin
                    if (addr == 6'(16 + 4 * i)) begin
                        rdata[CNT_W-1:0] = cnt[i];
                    end
                end
            end
        endcase
    end

endmodule

// File: tb/tb_prism_aux_engine.sv
// Directed scoreboard bench for prism_aux_engine at default parameters (SHIFT_W=8, CNT_W=24, NUM_CNT=2, EVT_W=4).
module tb_prism_aux_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic        wr;
    logic [31:0] rdata;
    logic        enable;
    logic        halt;
    logic [1:0]  ctl_load;
    logic [1:0]  ctl_dec;
    logic        ctl_shift;
    logic        ctl_evt_clr;
    logic        ctl_evt_inc;
    logic [3:0]  ser_in;
    logic        shift_bit;
    logic [1:0]  cnt_zero;
    logic        cnt0_msb;
    logic        evt_match;
    logic        irq;

    typedef struct {
        string       tag;
        logic [31:0] value;
    } exp_t;

    exp_t        expQ[$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] d;

    prism_aux_engine dut (
        .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .wr(wr), .rdata(rdata),
        .enable(enable), .halt(halt), .ctl_load(ctl_load), .ctl_dec(ctl_dec),
        .ctl_shift(ctl_shift), .ctl_evt_clr(ctl_evt_clr), .ctl_evt_inc(ctl_evt_inc),
        .ser_in(ser_in), .shift_bit(shift_bit), .cnt_zero(cnt_zero), .cnt0_msb(cnt0_msb),
        .evt_match(evt_match), .irq(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] outVec();
        return {26'b0, shift_bit, cnt_zero, cnt0_msb, evt_match, irq};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expectVal(input string tag, input logic [31:0] value);
        exp_t e;
        e.tag   = tag;
        e.value = value;
        expQ.push_back(e);
    endtask

    task automatic checkOutput(input logic [31:0] observed);
        exp_t e;
        total++;
        if (expQ.size() == 0) begin
            bad++;
            $error("[TB] FAIL scoreboard_underflow observed=%h expected=none", observed);
        end else begin
            e = expQ.pop_front();
            assert (observed === e.value) else begin
                bad++;
                $error("[TB] FAIL %s observed=%h expected=%h", e.tag, observed, e.value);
            end
        end
    endtask

    task automatic applyStimulus(input logic [1:0] ld, input logic [1:0] dc,
                                 input logic sh, input logic clr, input logic inc);
        ctl_load    = ld;
        ctl_dec     = dc;
        ctl_shift   = sh;
        ctl_evt_clr = clr;
        ctl_evt_inc = inc;
        tick();
        ctl_load    = '0;
        ctl_dec     = '0;
        ctl_shift   = 1'b0;
        ctl_evt_clr = 1'b0;
        ctl_evt_inc = 1'b0;
    endtask

    task automatic busWrite(input logic [5:0] a, input logic [31:0] v);
        addr  = a;
        wdata = v;
        wr    = 1'b1;
        tick();
        wr    = 1'b0;
    endtask

    task automatic readReg(input logic [5:0] a, output logic [31:0] v);
        @(negedge clk);
        addr = a;
        #1;
        v = rdata;
    endtask

    task automatic expectReg(input string tag, input logic [5:0] a, input logic [31:0] v);
        logic [31:0] r;
        expectVal(tag, v);
        readReg(a, r);
        checkOutput(r);
    endtask

    initial begin
        rst = 1'b1; addr = '0; wdata = '0; wr = 1'b0; enable = 1'b0; halt = 1'b0;
        ctl_load = '0; ctl_dec = '0; ctl_shift = 1'b0; ctl_evt_clr = 1'b0; ctl_evt_inc = 1'b0;
        ser_in = '0;
        repeat (3) tick();
        rst = 1'b0;

        $display("[TB] reset state");
        expectVal("reset_outputs", 32'h1A);
        checkOutput(outVec());
        expectReg("reset_status", 6'h0C, 32'h0);
        expectReg("reset_ctrl", 6'h00, 32'h0);
        enable = 1'b1;

        $display("[TB] countdown counters");
        busWrite(6'h00, 32'h0001_0000);
        busWrite(6'h10, 32'd3);
        applyStimulus(2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
        expectReg("cnt0_load", 6'h10, 32'd3);
        applyStimulus(2'b00, 2'b01, 1'b0, 1'b0, 1'b0);
        expectReg("cnt0_dec1", 6'h10, 32'd2);
        applyStimulus(2'b00, 2'b01, 1'b0, 1'b0, 1'b0);
        expectReg("cnt0_dec2", 6'h10, 32'd1);
        applyStimulus(2'b00, 2'b01, 1'b0, 1'b0, 1'b0);
        expectReg("cnt0_dec3", 6'h10, 32'd0);
        expectReg("status_zero_hit", 6'h0C, 32'h1);
        applyStimulus(2'b00, 2'b01, 1'b0, 1'b0, 1'b0);
        expectReg("cnt0_hold_zero", 6'h10, 32'd0);
        expectVal("irq_enabled", 32'h1);
        checkOutput({31'b0, irq});
        busWrite(6'h00, 32'h0);
        expectVal("irq_masked", 32'h0);
        checkOutput({31'b0, irq});
        busWrite(6'h0C, 32'h1);
        expectReg("status_w1c", 6'h0C, 32'h0);
        busWrite(6'h10, 32'd0);
        applyStimulus(2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
        expectReg("load_zero_no_status", 6'h0C, 32'h0);
        busWrite(6'h14, 32'd7);
        applyStimulus(2'b10, 2'b00, 1'b0, 1'b0, 1'b0);
        applyStimulus(2'b00, 2'b10, 1'b0, 1'b0, 1'b0);
        expectReg("cnt1_dec", 6'h14, 32'd6);
        expectVal("cnt_zero_mixed", 32'h1);
        checkOutput({30'b0, cnt_zero});

        $display("[TB] halt and enable gating");
        busWrite(6'h10, 32'd5);
        applyStimulus(2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
        halt = 1'b1; ctl_dec = 2'b01; ctl_evt_inc = 1'b1;
        repeat (3) tick();
        expectReg("halt_cnt0", 6'h10, 32'd5);
        expectReg("halt_evt", 6'h08, 32'h0);
        halt = 1'b0;
        tick();
        ctl_dec = 2'b00; ctl_evt_inc = 1'b0;
        expectReg("resume_cnt0", 6'h10, 32'd4);
        expectReg("resume_evt", 6'h08, 32'h0001_0000);
        enable = 1'b0;
        applyStimulus(2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
        expectReg("disabled_load", 6'h10, 32'd4);
        enable = 1'b1;
        applyStimulus(2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
        tick();
        expectReg("evt_clr_edge", 6'h0C, 32'h10);
        busWrite(6'h0C, 32'h1F);
        expectReg("status_clear_all", 6'h0C, 32'h0);

        $display("[TB] event counter");
        busWrite(6'h08, 32'd2);
        applyStimulus(2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
        applyStimulus(2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
        expectVal("evt_match_hit", 32'h1);
        checkOutput({31'b0, evt_match});
        tick();
        expectReg("evt_status", 6'h0C, 32'h10);
        expectReg("evt_readback", 6'h08, 32'h0002_0002);
        for (int i = 0; i < 14; i++) applyStimulus(2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
        expectReg("evt_wrap", 6'h08, 32'h0000_0002);
        expectVal("evt_match_off", 32'h0);
        checkOutput({31'b0, evt_match});
        applyStimulus(2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
        applyStimulus(2'b00, 2'b00, 1'b0, 1'b1, 1'b1);
        expectReg("evt_clr_inc_hold", 6'h08, 32'h0001_0002);
        applyStimulus(2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
        busWrite(6'h0C, 32'h1F);
        expectReg("evt_status_clear", 6'h0C, 32'h0);

        $display("[TB] shift register");
        busWrite(6'h00, 32'h4);
        ser_in = 4'b0100;
        busWrite(6'h04, 32'h81);
        expectVal("shift_bit_msb", 32'h1);
        checkOutput({31'b0, shift_bit});
        applyStimulus(2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
        expectVal("shift_bit_after", 32'h0);
        checkOutput({31'b0, shift_bit});
        expectReg("shift_left", 6'h04, 32'h03);
        addr = 6'h04; wdata = 32'h55; wr = 1'b1; ctl_shift = 1'b1;
        tick();
        wr = 1'b0; ctl_shift = 1'b0;
        expectReg("write_beats_shift", 6'h04, 32'h55);
        busWrite(6'h00, 32'h5);
        expectVal("shift_bit_lsb", 32'h1);
        checkOutput({31'b0, shift_bit});
        applyStimulus(2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
        expectReg("shift_right", 6'h04, 32'hAA);
        ser_in = 4'b1011;
        applyStimulus(2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
        expectReg("shift_sin_sel", 6'h04, 32'h55);

        $display("[TB] status set vs clear");
        busWrite(6'h00, 32'h0);
        busWrite(6'h10, 32'd1);
        applyStimulus(2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
        applyStimulus(2'b00, 2'b01, 1'b0, 1'b0, 1'b0);
        expectReg("status_pre_race", 6'h0C, 32'h1);
        applyStimulus(2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
        addr = 6'h0C; wdata = 32'h1; wr = 1'b1; ctl_dec = 2'b01;
        tick();
        wr = 1'b0; ctl_dec = 2'b00;
        expectReg("set_beats_w1c", 6'h0C, 32'h1);
        busWrite(6'h0C, 32'h1);
        expectReg("status_after_w1c", 6'h0C, 32'h0);

        $display("[TB] chain0 and mid-run reset");
        busWrite(6'h00, 32'h8);
        busWrite(6'h10, 32'h40_0001);
        applyStimulus(2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
        expectVal("msb_before_chain", 32'h0);
        checkOutput({31'b0, cnt0_msb});
        applyStimulus(2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
        expectVal("msb_after_chain", 32'h1);
        checkOutput({31'b0, cnt0_msb});
        expectReg("chain_shift", 6'h10, 32'h80_0002);
        expectVal("cnt_zero_none", 32'h0);
        checkOutput({30'b0, cnt_zero});
        expectReg("unmapped_cnt2", 6'h18, 32'h0);
        expectReg("unmapped_misaligned", 6'h11, 32'h0);
        expectReg("unmapped_high", 6'h20, 32'h0);
        rst = 1'b1; ctl_dec = 2'b01; ctl_shift = 1'b1; ctl_evt_inc = 1'b1;
        tick();
        rst = 1'b0; ctl_dec = 2'b00; ctl_shift = 1'b0; ctl_evt_inc = 1'b0;
        expectVal("rerst_outputs", 32'h1A);
        checkOutput(outVec());
        expectReg("rerst_cnt0", 6'h10, 32'h0);
        expectReg("rerst_cnt1", 6'h14, 32'h0);
        expectReg("rerst_shift", 6'h04, 32'h0);
        expectReg("rerst_ctrl", 6'h00, 32'h0);
        expectReg("rerst_evt", 6'h08, 32'h0);
        expectReg("rerst_status", 6'h0C, 32'h0);

        total++;
        assert (expQ.size() == 0) else begin
            bad++;
            $error("[TB] FAIL scoreboard_leftover observed=%0d expected=0", expQ.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
